// File: rtl/tlp_pkt_fifo.sv
// Single-clock TLP packet FIFO with write-side commit/discard, so the reader only
// ever sees complete packets. Supports FWFT or registered-read output modes.
module tlp_pkt_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter bit FWFT       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WrEn,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic                  WrLast,
    input  logic                  WrDiscard,
    input  logic                  RdEn,
    input  logic [DEPTH_LOG2:0]   AfThresh,
    input  logic [DEPTH_LOG2:0]   AeThresh,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  DataValid,
    output logic                  Full,
    output logic                  Empty,
    output logic                  AlmostFull,
    output logic                  AlmostEmpty,
    output logic [DEPTH_LOG2:0]   Count,
    output logic                  WrErr,
    output logic                  RdErr
);
    localparam int              PW      = DEPTH_LOG2 + 1;
    localparam int              DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [PW-1:0]   PTR_ONE = PW'(1);
    localparam logic [PW-1:0]   DEPTH_W = PW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Pointers carry an extra wrap bit so full and empty stay distinguishable.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] cm_ptr_q, cm_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          wr_err_q, rd_err_q;

    logic [PW-1:0] used;
    logic [PW-1:0] count;
    logic          full, empty;
    logic          wr_acc, rd_acc;

    assign used   = wr_ptr_q - rd_ptr_q;
    assign count  = cm_ptr_q - rd_ptr_q;
    assign full   = (used == DEPTH_W);
    assign empty  = (count == '0);
    assign wr_acc = WrEn && !full && !WrDiscard;
    assign rd_acc = RdEn && !empty;

    assign Full        = full;
    assign Empty       = empty;
    assign Count       = count;
    assign AlmostFull  = (used >= AfThresh);
    assign AlmostEmpty = (count <= AeThresh);
    assign WrErr       = wr_err_q;
    assign RdErr       = rd_err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        cm_ptr_d = cm_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // Discard wins over a same-cycle write, which wr_acc already excludes.
        if (WrDiscard) begin
            wr_ptr_d = cm_ptr_q;
        end else if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (wr_acc && WrLast) begin
            cm_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            cm_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cm_ptr_q <= cm_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_err_q <= WrEn && (full || WrDiscard);
            rd_err_q <= RdEn && empty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= DataIn;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign DataOut   = mem[rd_ptr_q[DEPTH_LOG2-1:0]];
            assign DataValid = !empty;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  dval_q;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    dout_q <= '0;
                    dval_q <= 1'b0;
                end else begin
                    dval_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
                    end
                end
            end

            assign DataOut   = dout_q;
            assign DataValid = dval_q;
        end
    endgenerate

endmodule

// File: tb/tb_tlp_pkt_fifo.sv
// Bench for tlp_pkt_fifo: an FWFT and a registered-read instance share stimulus;
// a queue of committed words predicts what the reader must see.
module tb_tlp_pkt_fifo;
    localparam int DW = 32;
    localparam int DL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          WrEn, WrLast, WrDiscard, RdEn;
    logic [DW-1:0] DataIn;
    logic [DL:0]   AfThresh, AeThresh;

    logic [DW-1:0] f_DataOut, r_DataOut;
    logic          f_DataValid, f_Full, f_Empty, f_AlmostFull, f_AlmostEmpty, f_WrErr, f_RdErr;
    logic          r_DataValid, r_Full, r_Empty, r_AlmostFull, r_AlmostEmpty, r_WrErr, r_RdErr;
    logic [DL:0]   f_Count, r_Count;

    int vectors     = 0;
    int miscompares = 0;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] pend_q[$];

    always #5 clk = ~clk;

    tlp_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(rst), .WrEn(WrEn), .DataIn(DataIn), .WrLast(WrLast),
        .WrDiscard(WrDiscard), .RdEn(RdEn), .AfThresh(AfThresh), .AeThresh(AeThresh),
        .DataOut(f_DataOut), .DataValid(f_DataValid), .Full(f_Full), .Empty(f_Empty),
        .AlmostFull(f_AlmostFull), .AlmostEmpty(f_AlmostEmpty), .Count(f_Count),
        .WrErr(f_WrErr), .RdErr(f_RdErr)
    );

    tlp_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .FWFT(1'b0)) u_reg (
        .clk(clk), .rst(rst), .WrEn(WrEn), .DataIn(DataIn), .WrLast(WrLast),
        .WrDiscard(WrDiscard), .RdEn(RdEn), .AfThresh(AfThresh), .AeThresh(AeThresh),
        .DataOut(r_DataOut), .DataValid(r_DataValid), .Full(r_Full), .Empty(r_Empty),
        .AlmostFull(r_AlmostFull), .AlmostEmpty(r_AlmostEmpty), .Count(r_Count),
        .WrErr(r_WrErr), .RdErr(r_RdErr)
    );

    task automatic idle();
        WrEn = 1'b0; WrLast = 1'b0; WrDiscard = 1'b0; RdEn = 1'b0; DataIn = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        sb_q.delete();
        pend_q.delete();
    endtask

    // Drive one accepted write; the word becomes expected output once its packet commits.
    task automatic push_word(input logic [DW-1:0] d, input bit last);
        WrEn = 1'b1; DataIn = d; WrLast = last;
        tick();
        idle();
        pend_q.push_back(d);
        if (last) begin
            foreach (pend_q[i]) sb_q.push_back(pend_q[i]);
            pend_q.delete();
        end
        $display("wr %h last=%0d", d, last);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (f_Count !== 5'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", f_Count); end
        vectors++; if (f_Empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got=%b exp=1", f_Empty); end
        vectors++; if (f_Full !== 1'b0) begin miscompares++; $display("FAIL reset_full got=%b exp=0", f_Full); end
        vectors++; if (f_DataValid !== 1'b0) begin miscompares++; $display("FAIL reset_fvalid got=%b exp=0", f_DataValid); end
        vectors++; if (r_DataValid !== 1'b0 || r_DataOut !== '0) begin miscompares++; $display("FAIL reset_rout got=%b/%h exp=0/0", r_DataValid, r_DataOut); end
        vectors++; if (f_WrErr !== 1'b0 || f_RdErr !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b%b exp=00", f_WrErr, f_RdErr); end
        AfThresh = 5'd0; AeThresh = 5'd0; #1;
        vectors++; if (f_AlmostFull !== 1'b1) begin miscompares++; $display("FAIL af_zero got=%b exp=1", f_AlmostFull); end
        vectors++; if (f_AlmostEmpty !== 1'b1) begin miscompares++; $display("FAIL ae_empty got=%b exp=1", f_AlmostEmpty); end
        AfThresh = 5'd14; AeThresh = 5'd2; #1;
        vectors++; if (f_AlmostFull !== 1'b0) begin miscompares++; $display("FAIL af_14_empty got=%b exp=0", f_AlmostFull); end
    endtask

    task automatic test_basic_order();
        logic [DW-1:0] exp;
        do_reset();
        push_word(32'hA1, 1'b0);
        vectors++; if (f_Count !== 5'd0) begin miscompares++; $display("FAIL basic_cnt_a1 got=%0d exp=0", f_Count); end
        push_word(32'hA2, 1'b0);
        vectors++; if (f_Count !== 5'd0 || f_DataValid !== 1'b0) begin miscompares++; $display("FAIL basic_cnt_a2 got=%0d/%b exp=0/0", f_Count, f_DataValid); end
        push_word(32'hA3, 1'b1);
        vectors++; if (f_Count !== 5'd3) begin miscompares++; $display("FAIL basic_cnt_a3 got=%0d exp=3", f_Count); end
        vectors++; if (f_DataOut !== 32'hA1 || f_DataValid !== 1'b1) begin miscompares++; $display("FAIL basic_fwft_head got=%h/%b exp=a1/1", f_DataOut, f_DataValid); end
        AeThresh = 5'd2; #1;
        vectors++; if (f_AlmostEmpty !== 1'b0) begin miscompares++; $display("FAIL ae_2_of_3 got=%b exp=0", f_AlmostEmpty); end
        AeThresh = 5'd3; #1;
        vectors++; if (f_AlmostEmpty !== 1'b1) begin miscompares++; $display("FAIL ae_3_of_3 got=%b exp=1", f_AlmostEmpty); end
        AeThresh = 5'd2;
        for (int i = 0; i < 3; i++) begin
            exp = sb_q.pop_front();
            vectors++; if (f_DataOut !== exp || f_DataValid !== 1'b1) begin miscompares++; $display("FAIL basic_pop%0d got=%h/%b exp=%h/1", i, f_DataOut, f_DataValid, exp); end
            $display("rd %h", f_DataOut);
            RdEn = 1'b1; tick(); idle();
        end
        vectors++; if (f_Empty !== 1'b1 || f_DataValid !== 1'b0) begin miscompares++; $display("FAIL basic_empty got=%b/%b exp=1/0", f_Empty, f_DataValid); end
    endtask

    task automatic test_discard();
        logic [DW-1:0] exp;
        do_reset();
        push_word(32'hC1, 1'b0);
        push_word(32'hC2, 1'b1);
        for (int i = 0; i < 5; i++) push_word(32'hD0 + DW'(i), 1'b0);
        AfThresh = 5'd7; #1;
        vectors++; if (f_AlmostFull !== 1'b1) begin miscompares++; $display("FAIL disc_used7_af7 got=%b exp=1", f_AlmostFull); end
        AfThresh = 5'd8; #1;
        vectors++; if (f_AlmostFull !== 1'b0) begin miscompares++; $display("FAIL disc_used7_af8 got=%b exp=0", f_AlmostFull); end
        vectors++; if (f_Count !== 5'd2) begin miscompares++; $display("FAIL disc_cnt_pre got=%0d exp=2", f_Count); end
        // Discard with a colliding write/last: the write is dropped and flagged.
        WrDiscard = 1'b1; WrEn = 1'b1; WrLast = 1'b1; DataIn = 32'hBAD;
        tick(); idle();
        pend_q.delete();
        vectors++; if (f_WrErr !== 1'b1) begin miscompares++; $display("FAIL disc_wrerr got=%b exp=1", f_WrErr); end
        vectors++; if (f_Count !== 5'd2) begin miscompares++; $display("FAIL disc_cnt_post got=%0d exp=2", f_Count); end
        AfThresh = 5'd2; #1;
        vectors++; if (f_AlmostFull !== 1'b1) begin miscompares++; $display("FAIL disc_used2_af2 got=%b exp=1", f_AlmostFull); end
        AfThresh = 5'd3; #1;
        vectors++; if (f_AlmostFull !== 1'b0) begin miscompares++; $display("FAIL disc_used2_af3 got=%b exp=0", f_AlmostFull); end
        AfThresh = 5'd14;
        push_word(32'hE1, 1'b0);
        push_word(32'hE2, 1'b1);
        vectors++; if (f_Count !== 5'd4) begin miscompares++; $display("FAIL disc_cnt_new got=%0d exp=4", f_Count); end
        for (int i = 0; i < 4; i++) begin
            exp = sb_q.pop_front();
            vectors++; if (f_DataOut !== exp) begin miscompares++; $display("FAIL disc_pop%0d got=%h exp=%h", i, f_DataOut, exp); end
            $display("rd %h", f_DataOut);
            RdEn = 1'b1; tick(); idle();
        end
        vectors++; if (f_Empty !== 1'b1) begin miscompares++; $display("FAIL disc_empty got=%b exp=1", f_Empty); end
    endtask

    task automatic test_full();
        logic [DW-1:0] exp;
        do_reset();
        AfThresh = 5'd14;
        for (int i = 0; i < 15; i++) push_word(32'hF00 + DW'(i), 1'b0);
        vectors++; if (f_Full !== 1'b0) begin miscompares++; $display("FAIL full_at15 got=%b exp=0", f_Full); end
        push_word(32'hF0F, 1'b1);
        vectors++; if (f_Full !== 1'b1 || f_AlmostFull !== 1'b1) begin miscompares++; $display("FAIL full_at16 got=%b/%b exp=1/1", f_Full, f_AlmostFull); end
        vectors++; if (f_Count !== 5'd16) begin miscompares++; $display("FAIL full_cnt got=%0d exp=16", f_Count); end
        WrEn = 1'b1; DataIn = 32'hDEAD; tick(); idle();
        vectors++; if (f_WrErr !== 1'b1 || f_Count !== 5'd16) begin miscompares++; $display("FAIL full_wrerr got=%b/%0d exp=1/16", f_WrErr, f_Count); end
        tick();
        vectors++; if (f_WrErr !== 1'b0) begin miscompares++; $display("FAIL full_wrerr_pulse got=%b exp=0", f_WrErr); end
        // Read plus write at Full: only the pop happens.
        RdEn = 1'b1; WrEn = 1'b1; DataIn = 32'hBEEF; tick(); idle();
        void'(sb_q.pop_front());
        vectors++; if (f_Full !== 1'b0 || f_Count !== 5'd15) begin miscompares++; $display("FAIL full_rdwr got=%b/%0d exp=0/15", f_Full, f_Count); end
        vectors++; if (f_WrErr !== 1'b1) begin miscompares++; $display("FAIL full_rdwr_wrerr got=%b exp=1", f_WrErr); end
        for (int i = 0; i < 15; i++) begin
            exp = sb_q.pop_front();
            vectors++; if (f_DataOut !== exp) begin miscompares++; $display("FAIL full_drain%0d got=%h exp=%h", i, f_DataOut, exp); end
            RdEn = 1'b1; tick(); idle();
        end
        vectors++; if (f_Empty !== 1'b1) begin miscompares++; $display("FAIL full_empty got=%b exp=1", f_Empty); end
    endtask

    task automatic test_wrap();
        int wr_idx = 0;
        int cyc = 0;
        bit do_wr, do_rd, last;
        logic [DW-1:0] exp;
        do_reset();
        while ((wr_idx < 40 || sb_q.size() != 0) && cyc < 2000) begin
            do_wr = (wr_idx < 40) && !f_Full && ($urandom_range(0, 3) != 0);
            do_rd = ($urandom_range(0, 1) == 1) && !f_Empty;
            if (do_rd) begin
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++; $display("FAIL wrap_phantom got=%h exp=none", f_DataOut);
                end else begin
                    exp = sb_q.pop_front();
                    if (f_DataOut !== exp) begin miscompares++; $display("FAIL wrap_data got=%h exp=%h", f_DataOut, exp); end
                    $display("rd %h", f_DataOut);
                end
            end
            last   = (wr_idx % 3 == 2) || (wr_idx == 39);
            WrEn   = do_wr;
            WrLast = do_wr && last;
            DataIn = 32'hC000_0000 + DW'(wr_idx);
            RdEn   = do_rd;
            tick(); idle();
            cyc++;
            if (do_wr) begin
                pend_q.push_back(32'hC000_0000 + DW'(wr_idx));
                if (last) begin
                    foreach (pend_q[i]) sb_q.push_back(pend_q[i]);
                    pend_q.delete();
                end
                wr_idx++;
            end
            vectors++;
            if (f_Count !== 5'(sb_q.size()) || f_Count > 5'd16) begin
                miscompares++; $display("FAIL wrap_count got=%0d exp=%0d", f_Count, sb_q.size());
            end
        end
        vectors++; if (cyc >= 2000) begin miscompares++; $display("FAIL wrap_timeout got=%0d cycles exp<2000", cyc); end
    endtask

    task automatic test_fwft0();
        do_reset();
        push_word(32'hB1, 1'b0);
        push_word(32'hB2, 1'b1);
        vectors++; if (r_DataValid !== 1'b0 || r_Count !== 5'd2) begin miscompares++; $display("FAIL reg_idle got=%b/%0d exp=0/2", r_DataValid, r_Count); end
        RdEn = 1'b1; tick();
        vectors++; if (r_DataValid !== 1'b1 || r_DataOut !== 32'hB1) begin miscompares++; $display("FAIL reg_rd1 got=%b/%h exp=1/b1", r_DataValid, r_DataOut); end
        tick();
        vectors++; if (r_DataValid !== 1'b1 || r_DataOut !== 32'hB2) begin miscompares++; $display("FAIL reg_rd2 got=%b/%h exp=1/b2", r_DataValid, r_DataOut); end
        tick(); idle();
        vectors++; if (r_RdErr !== 1'b1 || r_DataValid !== 1'b0) begin miscompares++; $display("FAIL reg_rderr got=%b/%b exp=1/0", r_RdErr, r_DataValid); end
        vectors++; if (r_DataOut !== 32'hB2) begin miscompares++; $display("FAIL reg_hold got=%h exp=b2", r_DataOut); end
        tick();
        vectors++; if (r_RdErr !== 1'b0) begin miscompares++; $display("FAIL reg_rderr_pulse got=%b exp=0", r_RdErr); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        push_word(32'h31, 1'b0);
        push_word(32'h32, 1'b0);
        push_word(32'h33, 1'b1);
        for (int i = 0; i < 4; i++) push_word(32'h40 + DW'(i), 1'b0);
        vectors++; if (f_Count !== 5'd3) begin miscompares++; $display("FAIL mid_precount got=%0d exp=3", f_Count); end
        do_reset();
        vectors++; if (f_Count !== 5'd0 || f_Empty !== 1'b1 || f_Full !== 1'b0) begin miscompares++; $display("FAIL mid_status got=%0d/%b/%b exp=0/1/0", f_Count, f_Empty, f_Full); end
        vectors++; if (f_DataValid !== 1'b0 || r_DataValid !== 1'b0) begin miscompares++; $display("FAIL mid_valid got=%b/%b exp=0/0", f_DataValid, r_DataValid); end
        push_word(32'h77, 1'b1);
        vectors++; if (f_Count !== 5'd1 || f_DataOut !== 32'h77) begin miscompares++; $display("FAIL mid_fresh got=%0d/%h exp=1/77", f_Count, f_DataOut); end
    endtask

    initial begin
        idle();
        rst = 1'b0;
        AfThresh = 5'd14;
        AeThresh = 5'd2;
        repeat (2) tick();
        test_reset();
        test_basic_order();
        test_discard();
        test_full();
        test_wrap();
        test_fwft0();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
